// File: rtl/interval_gen_pkg.sv
// ============================================================================
// interval_gen_pkg : shared FSM encoding and default counter width for the
//                    interval generator and its paired start/stop measurer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package interval_gen_pkg;

  // The measurer imports this constant so both ends agree on the counter width.
  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/interval_cmd_fifo.sv
// ============================================================================
// interval_cmd_fifo : synchronous first-word-fall-through command FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module interval_cmd_fifo
  import interval_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/interval_generator.sv
// ============================================================================
// interval_generator : turns interval commands into matched start/stop pulses.
// Build option: INTERVAL_GEN_FIFO_EN selects a FIFO_DEPTH command FIFO instead
//               of the single holding register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module interval_generator
  import interval_gen_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] interval_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             start_o,
  output logic             stop_o,
  output logic             busy_o,
  output logic             done_o
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic             q_push;
  logic             q_pop;
  logic             q_empty;
  logic             q_full;
  logic [WIDTH-1:0] q_dout;

  assign q_push  = valid_i && ready_o;
  assign ready_o = !q_full;

`ifdef INTERVAL_GEN_FIFO_EN
  interval_cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (q_push),
    .pop    (q_pop),
    .din    (interval_i),
    .dout   (q_dout),
    .full   (q_full),
    .empty  (q_empty)
  );
`else
  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;

  // Push needs an empty register and pop a full one, so they never coincide.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (q_push) begin
      hold_valid <= 1'b1;
      hold_data  <= interval_i;
    end else if (q_pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign q_empty = !hold_valid;
  assign q_full  = hold_valid;
  assign q_dout  = hold_data;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!q_empty) begin
          q_pop     = 1'b1;
          // A zero interval cannot be encoded by a start/stop pair.
          cnt_nxt   = (q_dout == '0) ? WIDTH'(1) : q_dout;
          state_nxt = S_START;
        end
      end
      S_START: state_nxt = S_RUN;
      S_RUN: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        if (cnt <= WIDTH'(1)) state_nxt = S_STOP;
      end
      S_STOP:  state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      start_o <= 1'b0;
      stop_o  <= 1'b0;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      start_o <= (state_nxt == S_START);
      stop_o  <= (state_nxt == S_STOP);
      done_o  <= (state_nxt == S_STOP);
      busy_o  <= (state_nxt != S_IDLE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_interval_generator.sv
// ============================================================================
// tb_interval_generator : scoreboard bench for interval_generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_interval_generator;

`ifdef INTERVAL_GEN_FIFO_EN
  localparam int QDEPTH = 4;
`else
  localparam int QDEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] interval;
  logic       valid;
  logic       ready;
  logic       start;
  logic       stop;
  logic       busy;
  logic       done;

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int n_starts  = 0;
  int n_stops   = 0;
  int start_cyc = 0;
  int last_stop = 0;
  bit in_seq    = 1'b0;
  bit have_stop = 1'b0;

  int unsigned sb[$];

  interval_generator #(
    .WIDTH      (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .interval_i (interval),
    .valid_i    (valid),
    .ready_o    (ready),
    .start_o    (start),
    .stop_o     (stop),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned eff(input logic [7:0] n);
    return (n == 8'd0) ? 1 : int'(n);
  endfunction

  // Measurer model: RUN length between a start and its stop is the reported count.
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      in_seq    = 1'b0;
      have_stop = 1'b0;
    end else begin
      if (start || stop) begin
        check_eq("start_stop_excl", int'(start && stop), 0);
        check_eq("done_vs_stop", int'(done), int'(stop));
      end else if (done) begin
        check_eq("done_alone", int'(done), 0);
      end
      if (start) begin
        n_starts++;
        check_eq("busy_at_start", int'(busy), 1);
        if (have_stop) check_eq("stop_to_start_ge3", int'(cyc - last_stop >= 3), 1);
        start_cyc = cyc;
        in_seq    = 1'b1;
      end
      if (stop) begin
        n_stops++;
        check_eq("stop_after_start", int'(in_seq), 1);
        check_eq("sb_nonempty_at_stop", int'(sb.size() != 0), 1);
        if (sb.size() != 0) check_eq("measured_interval", cyc - start_cyc - 1, int'(sb.pop_front()));
        last_stop = cyc;
        have_stop = 1'b1;
        in_seq    = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] n, output int acc);
    bit ok = 1'b0;
    acc = 0;
    tick();
    interval = n;
    valid    = 1'b1;
    for (int k = 0; k < 2000 && !ok; k++) begin
      if (ready) begin
        acc = cyc;
        sb.push_back(eff(n));
        ok = 1'b1;
      end
      tick();
    end
    valid = 1'b0;
    check_eq("send_accepted", int'(ok), 1);
  endtask

  task automatic wait_start(input int bound);
    bit seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      tick();
      seen = start;
    end
    check_eq("start_seen", int'(seen), 1);
  endtask

  task automatic wait_stops(input int target, input int bound);
    for (int k = 0; k < bound && n_stops < target; k++) tick();
    check_eq("stops_reached", int'(n_stops >= target), 1);
  endtask

  initial begin
    int acc;
    int base;
    int accepts;
    int s0;
    int p0;

    rstn     = 1'b0;
    valid    = 1'b0;
    interval = '0;
    repeat (3) tick();
    check_eq("rst_start", int'(start), 0);
    check_eq("rst_stop", int'(stop), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_ready", int'(ready), 1);
    rstn = 1'b1;
    tick();

    // Single commands from idle, including the clamped zero.
    send(8'd5, acc);
    wait_start(10);
    check_eq("latency_n5", cyc - acc, 2);
    wait_stops(1, 20);
    send(8'd0, acc);
    wait_start(10);
    check_eq("latency_n0", cyc - acc, 2);
    wait_stops(2, 20);

    send(8'd3, acc);
    send(8'd1, acc);
    send(8'd255, acc);
    wait_stops(5, 700);

    // Fill the queue behind a long sequence, then watch it drain.
    base = n_stops;
    send(8'd60, acc);
    wait_start(10);
    accepts = 0;
    for (int k = 0; k < 8; k++) begin
      if (!ready) break;
      interval = 8'(k);
      valid    = 1'b1;
      sb.push_back(eff(8'(k)));
      accepts++;
      tick();
    end
    valid = 1'b0;
    check_eq("accepts_until_full", accepts, QDEPTH);
    repeat (5) tick();
    check_eq("ready_low_while_full", int'(ready), 0);
    wait_stops(base + 1, 200);
    tick();
    check_eq("ready_in_gap", int'(ready), 0);
    tick();
    check_eq("ready_in_pop_cycle", int'(ready), 0);
    tick();
    check_eq("ready_after_pop", int'(ready), 1);
    check_eq("start_after_pop", int'(start), 1);
    wait_stops(base + 1 + QDEPTH, 400);

    // Reset in the middle of RUN with a queued command.
    send(8'd50, acc);
    wait_start(10);
    repeat (10) tick();
    send(8'd9, acc);
    tick();
    #2 rstn = 1'b0;
    #1;
    check_eq("midrst_start", int'(start), 0);
    check_eq("midrst_stop", int'(stop), 0);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_done", int'(done), 0);
    check_eq("midrst_ready", int'(ready), 1);
    sb.delete();
    s0 = n_starts;
    p0 = n_stops;
    tick();
    rstn = 1'b1;
    repeat (80) tick();
    check_eq("no_start_after_rst", n_starts, s0);
    check_eq("no_stop_after_rst", n_stops, p0);
    check_eq("idle_after_rst", int'(busy), 0);
    check_eq("ready_after_rst", int'(ready), 1);

    send(8'd7, acc);
    wait_start(10);
    check_eq("latency_post_rst", cyc - acc, 2);
    wait_stops(p0 + 1, 30);
    repeat (4) tick();
    check_eq("sb_drained", int'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/interval_generator.md
# interval_generator

Stimulus-side counterpart of the start/stop interval measurer. Accepts interval lengths over a valid/ready handshake and emits a matched one-cycle `start_o` pulse and `stop_o` pulse per command, so that a downstream start/stop cycle counter reports exactly the requested value. The block sits in front of the measurer in loopback test setups and drives any consumer of the same start/stop protocol.

## Interface
Parameters:
- `WIDTH`, 8: interval width, equal to the measurer's counter width.
- `FIFO_DEPTH`, 4: command queue depth, a power of two ≥ 2. Used only when `INTERVAL_GEN_FIFO_EN` is defined.

Ports:
- `clk_i` in 1: single clock; all logic on its rising edge.
- `rstn_i` in 1: asynchronous active-low reset.
- `interval_i` in WIDTH: requested count N.
- `valid_i` in 1: command valid.
- `ready_o` out 1: command can be accepted.
- `start_o` out 1: start pulse to the measurer, one cycle wide.
- `stop_o` out 1: stop pulse to the measurer, one cycle wide.
- `busy_o` out 1: a start/stop sequence is in progress.
- `done_o` out 1: one-cycle pulse marking sequence completion.

## Operation
- A command is accepted on a rising edge where `valid_i && ready_o`. `interval_i` is captured at that edge.
- Effective count: E = max(N, 1). N = 0 is clamped to 1, because the protocol cannot encode 0.
- FSM states: IDLE, START, RUN, STOP, GAP.
  - IDLE: if a command is queued, pop it, load the down-counter with E and go to START. Otherwise stay.
  - START: `start_o`=1 for this one cycle. Go to RUN.
  - RUN: decrement the counter each cycle. Go to STOP when the counter reaches 0. RUN lasts exactly E cycles.
  - STOP: `stop_o`=1 and `done_o`=1 for this one cycle. Go to GAP.
  - GAP: one idle cycle so the measurer can reach its stopped state. Then go to IDLE.
- `busy_o`=1 in every state except IDLE.
- Internal counter is WIDTH bits. E ≤ 2^WIDTH−1, so there is no wrap-around. It is never decremented below 0.
- `start_o` and `stop_o` are never high in the same cycle.
- Registered outputs: `start_o`, `stop_o`, `done_o`, `busy_o`.
- `ready_o` is combinational from queue status only. It never depends on `valid_i`.
- Simultaneous push and pop in one cycle is legal, including when the queue is full. The pop frees the slot in the same cycle.

## Timing
- Reset (asynchronous, while `rstn_i`=0):
  - `start_o`, `stop_o`, `busy_o`, `done_o` = 0.
  - FSM goes to IDLE and the queue is emptied.
  - `ready_o` = 1.
- Reset mid-sequence:
  - No `stop_o` is emitted for the sequence that was interrupted.
  - Queued commands are dropped.
- Latency:
  - Command accepted at edge A while IDLE with an empty queue gives `start_o` high in cycle A+2. One cycle is used for the IDLE pop and one for START.
  - `start_o` high in cycle T gives `stop_o` high in cycle T+E+1.
  - The measurer then reports E−1+1 = E, i.e. `counter_o` = E with `valid_o`, two cycles after `stop_o`.
- Back-to-back commands: the next `start_o` is in cycle T+E+4 at the earliest. `stop_o` and the next `start_o` are ≥ 3 cycles apart.
- `done_o` coincides with `stop_o`.

## Configuration
- `INTERVAL_GEN_FIFO_EN` defined: commands are queued in a FIFO of `FIFO_DEPTH` entries. `ready_o` = not full, so commands may be accepted while busy.
- `INTERVAL_GEN_FIFO_EN` undefined: a single holding register replaces the FIFO.
  - `ready_o` = holding register empty.
  - One command may wait while a sequence runs.
  - `FIFO_DEPTH` is ignored.

## Structure
- Shared package `interval_gen_pkg`: FSM state encodings (3-bit: IDLE, START, RUN, STOP, GAP) and the default WIDTH constant. The measurer reuses this constant so both ends agree on the counter width.
- One sub-module: `interval_cmd_fifo`, a synchronous FIFO.
  - Ports: push, pop, din, dout, full, empty.
  - Reset: asynchronous active-low.
  - Instantiated only under `INTERVAL_GEN_FIFO_EN`.

## Test plan
- N=5 accepted when idle → `start_o` in cycle T, `stop_o` in cycle T+6, `done_o` in T+6. A paired measurer reports 5 with `valid_o`.
- N=0 → `stop_o` at T+2. The measurer reports 1. There is no hang and no extra pulses.
- FIFO enabled, commands 3, 1, 255 pushed back-to-back → pulse pairs with spacing 4, 2 and 256 cycles. Next start is 3 cycles after each stop. The measurer reports 3, 1, 255.
- FIFO enabled, `valid_i` held high during a long sequence (N=200) → `ready_o` drops after 4 further accepts. It rises the cycle after the first pop. No command is lost or duplicated.
- `rstn_i` pulsed low in RUN of N=50 → all outputs 0 immediately, no `stop_o`. After release, `ready_o`=1 and the queue is empty.
- FIFO disabled: second command accepted while busy, third blocked (`ready_o`=0) until the pop at the next IDLE.
